// File: rtl/display_scan_controller_pkg.sv
// rtl/display_scan_controller_pkg.sv - shared scan constants, state enum and digit helpers
package display_scan_controller_pkg;

   localparam int NUM_DIGITS  = 6;
   localparam int DWELL_TICKS = 8;
   localparam int BLANK_TICKS = 1;

   localparam int SEL_W = $clog2(NUM_DIGITS);
   localparam int CNT_W = $clog2(DWELL_TICKS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_ON    = 2'd2,
      ST_OFF   = 2'd3
   } scan_state_t;

   // Digit indices shared with bcd_segment_mux (left to right on the display)
   localparam logic [SEL_W-1:0] HOURS_MSD   = 3'd0;
   localparam logic [SEL_W-1:0] HOURS_LSD   = 3'd1;
   localparam logic [SEL_W-1:0] MINUTES_MSD = 3'd2;
   localparam logic [SEL_W-1:0] MINUTES_LSD = 3'd3;
   localparam logic [SEL_W-1:0] SECONDS_MSD = 3'd4;
   localparam logic [SEL_W-1:0] SECONDS_LSD = 3'd5;

   function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [SEL_W-1:0] sel);
      digit_onehot = NUM_DIGITS'(1) << sel;
   endfunction

endpackage

// File: rtl/display_scan_controller_scan_pwm_timer.sv
// rtl/display_scan_controller_scan_pwm_timer.sv - per-slot tick counter and brightness compare
module scan_pwm_timer
   import display_scan_controller_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       tick,
   input  logic       load,
   input  logic [2:0] brightness,
   output logic       slot_end,
   output logic       blank_done,
   output logic       on_done
);

   logic [CNT_W-1:0] tick_cnt;
   logic [2:0]       bright_q;
   logic [CNT_W+1:0] on_last;

   // Count ticks within the slot; a load restarts the slot and captures brightness
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         tick_cnt <= '0;
         bright_q <= '0;
      end else if (tick) begin
         if (load) begin
            tick_cnt <= '0;
            bright_q <= brightness;
         end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
         end
      end
   end

   // Last ON tick position; beyond the slot end it never matches, so ON runs to slot end
   assign on_last    = (CNT_W+2)'(BLANK_TICKS) + (CNT_W+2)'(bright_q);
   assign slot_end   = (tick_cnt == CNT_W'(DWELL_TICKS - 1));
   assign blank_done = (tick_cnt == CNT_W'(BLANK_TICKS - 1));
   assign on_done    = (on_last == (CNT_W+2)'(tick_cnt));

endmodule

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - digit scan sequencer with blanking, PWM and blink masking
module display_scan_controller
   import display_scan_controller_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  refresh_tick,
   input  logic [2:0]            brightness,
   input  logic [NUM_DIGITS-1:0] blink_mask,
   input  logic                  blink_phase,
   output logic [SEL_W-1:0]      segment_select,
   output logic [NUM_DIGITS-1:0] digit_en,
   output logic                  frame_start
);

   scan_state_t           state, state_nx;
   logic [SEL_W-1:0]      sel_nx;
   logic [NUM_DIGITS-1:0] den_nx;
   logic                  fs_nx;
   logic                  slot_end, blank_done, on_done;
   logic                  load;

   // A new slot begins on the first tick out of IDLE or at every slot wrap
   assign load = (state == ST_IDLE) || slot_end;

   scan_pwm_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .clear      (!en),
      .tick       (refresh_tick),
      .load       (load),
      .brightness (brightness),
      .slot_end   (slot_end),
      .blank_done (blank_done),
      .on_done    (on_done)
   );

   // Next state, select and output values; select only moves on entry to BLANK
   always_comb begin
      state_nx = state;
      sel_nx   = segment_select;
      fs_nx    = 1'b0;
      den_nx   = '0;
      if (!en) begin
         state_nx = ST_IDLE;
         sel_nx   = HOURS_MSD;
      end else if (refresh_tick) begin
         if (state == ST_IDLE) begin
            state_nx = ST_BLANK;
            sel_nx   = HOURS_MSD;
            fs_nx    = 1'b1;
         end else if (slot_end) begin
            state_nx = ST_BLANK;
            if (segment_select == SEL_W'(NUM_DIGITS - 1)) begin
               sel_nx = HOURS_MSD;
               fs_nx  = 1'b1;
            end else begin
               sel_nx = segment_select + SEL_W'(1);
            end
         end else if (state == ST_BLANK && blank_done) begin
            state_nx = ST_ON;
         end else if (state == ST_ON && on_done) begin
            state_nx = ST_OFF;
         end
      end
      if (state_nx == ST_ON && !(blink_mask[sel_nx] && blink_phase)) begin
         den_nx = digit_onehot(sel_nx);
      end
   end

   // Register state and all outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_IDLE;
         segment_select <= HOURS_MSD;
         digit_en       <= '0;
         frame_start    <= 1'b0;
      end else begin
         state          <= state_nx;
         segment_select <= sel_nx;
         digit_en       <= den_nx;
         frame_start    <= fs_nx;
      end
   end

endmodule
